// File: rtl/shadow_slow_ctl_if.sv
// CPU-bus and slow-RAM signal bundle for shadow_slow_ctl.
// The controller takes the slave modport. The CPU and slow-RAM side takes the master modport.
interface shadow_slow_ctl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_bank;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  shadow;
  logic        cpu_ready;
  logic [7:0]  cpu_slow_din;
  logic        slow_ce;
  logic        slow_we;
  logic [16:0] slow_addr;
  logic [7:0]  slow_din;
  logic [7:0]  slow_dout;
  logic        busy;

  modport master (
    output cpu_req, cpu_we, cpu_bank, cpu_addr, cpu_dout, shadow, slow_dout,
    input  cpu_ready, cpu_slow_din, slow_ce, slow_we, slow_addr, slow_din, busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_bank, cpu_addr, cpu_dout, shadow, slow_dout,
    output cpu_ready, cpu_slow_din, slow_ce, slow_we, slow_addr, slow_din, busy
  );
endinterface

// File: rtl/shadow_slow_ctl.sv
// Shadow-write FIFO and direct E0/E1 sequencer feeding the 1 MHz slow RAM, one access per slow slot.
// Optional feature: define SHADOW_SHR_EN to decode the bank 01 super-hi-res region ($2000-$9FFF, shadow[3]).
module shadow_slow_ctl #(
  parameter int FIFO_AW  = 2,
  parameter int SLOW_DIV = 14
) (
  input logic            clk_sys,
  input logic            reset,
  shadow_slow_ctl_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(SLOW_DIV);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDLAT, S_DONE} state_t;

  typedef struct packed {
    logic        bank0;
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  // ---------------------------------------------------------------- slot timer
  logic [CW-1:0] slot_cnt;
  logic          slot;

  assign slot = (slot_cnt == CW'(SLOW_DIV - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)     slot_cnt <= '0;
    else if (slot) slot_cnt <= '0;
    else           slot_cnt <= slot_cnt + 1'b1;
  end

  // ---------------------------------------------------------------- decode
  logic low_bank, in_txt1, in_hgr1, in_hgr2, in_shr;
  logic shadow_hit, direct_req;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    low_bank = (bus.cpu_bank[7:1] == 7'h00);
    in_txt1  = (bus.cpu_addr[15:10] == 6'b000001) && !bus.shadow[0];
    in_hgr1  = (bus.cpu_addr[15:13] == 3'b001)    && !bus.shadow[1];
    in_hgr2  = (bus.cpu_addr[15:13] == 3'b010)    && !bus.shadow[2];
`ifdef SHADOW_SHR_EN
    in_shr   = bus.cpu_bank[0] && (bus.cpu_addr >= 16'h2000) &&
               (bus.cpu_addr <= 16'h9FFF) && !bus.shadow[3];
`else
    in_shr   = 1'b0;
`endif
    shadow_hit = bus.cpu_req && bus.cpu_we && low_bank &&
                 (in_txt1 || in_hgr1 || in_hgr2 || in_shr);
    direct_req = bus.cpu_req && (bus.cpu_bank[7:1] == 7'b1110000);
  end

  // These shadow register bits have no function in this build.
  logic unused_shadow;
`ifdef SHADOW_SHR_EN
  assign unused_shadow = ^bus.shadow[7:4];
`else
  assign unused_shadow = ^bus.shadow[7:3];
`endif

  // ---------------------------------------------------------------- shadow FIFO
  entry_t             fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   fifo_cnt;
  logic               fifo_empty, fifo_full, push, pop;
  entry_t             in_entry, head;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (FIFO_AW + 1)'(DEPTH));
  // The pop decision uses the registered count, so a push is never popped in its own cycle.
  assign pop        = slot && !fifo_empty;
  assign push       = shadow_hit && (!fifo_full || pop);
  assign in_entry   = {bus.cpu_bank[0], bus.cpu_addr, bus.cpu_dout};
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: storage has no reset. Clearing the pointers and count is enough to discard its contents.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= in_entry;
  end

  // ---------------------------------------------------------------- direct FSM
  state_t     state;
  logic [7:0] slow_rd_q;
  logic       issue;

  // A direct access waits behind queued shadow writes. The FIFO always owns the slot first.
  assign issue = (state == S_WAIT) && slot && fifo_empty;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      slow_rd_q <= '0;
    end else begin
      case (state)
        S_IDLE:  if (direct_req) state <= S_WAIT;
        S_WAIT:  if (issue) state <= bus.cpu_we ? S_DONE : S_RDLAT;
        S_RDLAT: begin
          slow_rd_q <= bus.slow_dout;
          state     <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  // The strobe must coincide with the slot cycle itself, so the slow-RAM port is decoded
  // directly from the pop and issue conditions.
  always_comb begin
    bus.slow_ce   = 1'b0;
    bus.slow_we   = 1'b0;
    bus.slow_addr = '0;
    bus.slow_din  = '0;
    if (pop) begin
      bus.slow_ce   = 1'b1;
      bus.slow_we   = 1'b1;
      bus.slow_addr = {head.bank0, head.addr};
      bus.slow_din  = head.data;
    end else if (issue) begin
      bus.slow_ce   = 1'b1;
      bus.slow_we   = bus.cpu_we;
      bus.slow_addr = {bus.cpu_bank[0], bus.cpu_addr};
      bus.slow_din  = bus.cpu_we ? bus.cpu_dout : 8'h00;
    end
  end

  assign bus.cpu_ready = !((state == S_WAIT) || (state == S_RDLAT) ||
                           ((state == S_IDLE) && direct_req) ||
                           (shadow_hit && fifo_full && !pop));

  assign bus.cpu_slow_din = slow_rd_q;
  assign bus.busy         = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_shadow_slow_ctl.sv
// Directed bench for shadow_slow_ctl (FIFO_AW=2, SLOW_DIV=14) with a behavioural slow-RAM model.
// Expectations for the bank 01 $8000 write follow SHADOW_SHR_EN.
module tb_shadow_slow_ctl;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  shadow_slow_ctl_if bus ();

  shadow_slow_ctl #(.FIFO_AW(2), .SLOW_DIV(14)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int ce_pulses = 0;

  // Reference slot timer: 0..13, reset to 0.
  int   m_cnt;
  logic m_slot;
  always @(posedge clk_sys or posedge reset)
    if (reset) m_cnt <= 0;
    else       m_cnt <= (m_cnt == 13) ? 0 : m_cnt + 1;
  assign m_slot = (m_cnt == 13);

  // Slow RAM: synchronous, one-cycle read latency.
  logic [7:0] sram [0:131071];
  logic [7:0] sram_q = 8'h00;
  always @(posedge clk_sys)
    if (bus.slow_ce === 1'b1) begin
      if (bus.slow_we) sram[bus.slow_addr] <= bus.slow_din;
      else             sram_q <= sram[bus.slow_addr];
    end
  assign bus.slow_dout = sram_q;

  always @(negedge clk_sys)
    if (bus.slow_ce === 1'b1) begin
      ce_pulses++;
      checks++;
      if (!m_slot) begin
        errors++;
        $display("FAIL ce_outside_slot: slow_ce=1 at slot count %0d, required 13", m_cnt);
      end
    end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_bus();
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_bank = 8'h00;
    bus.cpu_addr = 16'h0000;
    bus.cpu_dout = 8'h00;
  endtask

  task automatic drive(input logic we, input logic [7:0] bank, input logic [15:0] addr,
                       input logic [7:0] d);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_bank = bank;
    bus.cpu_addr = addr;
    bus.cpu_dout = d;
  endtask

  task automatic wait_slot(input string tag);
    int n = 0;
    while (!m_slot && n < 40) begin
      step();
      n++;
    end
    if (!m_slot) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no slot within %0d cycles", tag, n);
    end
  endtask

  task automatic to_cnt0();
    wait_slot("sync");
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_bus();
    bus.shadow = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.cpu_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.slow_ce !== 1'b0 || bus.slow_we !== 1'b0) begin errors++; $display("FAIL rst_ce_we: got %b%b want 00", bus.slow_ce, bus.slow_we); end
    checks++; if (bus.slow_addr !== 17'h0 || bus.slow_din !== 8'h0) begin errors++; $display("FAIL rst_addr_din: got %h/%h want 0/0", bus.slow_addr, bus.slow_din); end
    checks++; if (bus.cpu_slow_din !== 8'h00) begin errors++; $display("FAIL rst_slow_din: got %h want 00", bus.cpu_slow_din); end
    reset = 1'b0;
  endtask

  task automatic test_shadow_basic();
    bus.shadow = 8'h00;
    to_cnt0();
    drive(1'b1, 8'h00, 16'h0400, 8'h41);
    #1;
    checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", bus.cpu_ready); end
    step();
    idle_bus();
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_queued: got %b want 1", bus.busy); end
    checks++; if (bus.slow_ce !== 1'b0) begin errors++; $display("FAIL basic_early_ce: got %b want 0", bus.slow_ce); end
    wait_slot("basic");
    checks++; if (bus.slow_ce !== 1'b1 || bus.slow_we !== 1'b1) begin errors++; $display("FAIL basic_ce_we: got %b%b want 11", bus.slow_ce, bus.slow_we); end
    checks++; if (bus.slow_addr !== 17'h00400 || bus.slow_din !== 8'h41) begin errors++; $display("FAIL basic_addr_din: got %h/%h want 00400/41", bus.slow_addr, bus.slow_din); end
    step();
    checks++; if (bus.busy !== 1'b0 || bus.slow_ce !== 1'b0) begin errors++; $display("FAIL basic_drain: busy=%b ce=%b want 0/0", bus.busy, bus.slow_ce); end
    checks++; if (sram[17'h00400] !== 8'h41) begin errors++; $display("FAIL basic_ram: got %h want 41", sram[17'h00400]); end
  endtask

  task automatic test_shadow_inhibit();
    bus.shadow = 8'h01;
    to_cnt0();
    drive(1'b1, 8'h00, 16'h0400, 8'h41);
    #1;
    checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL inh_ready: got %b want 1", bus.cpu_ready); end
    step();
    idle_bus();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL inh_busy: got %b want 0", bus.busy); end
    wait_slot("inh");
    checks++; if (bus.slow_ce !== 1'b0) begin errors++; $display("FAIL inh_ce: got %b want 0", bus.slow_ce); end
    step();
  endtask

  task automatic test_overflow();
    logic        stalled_ok;
    int          n;
    logic [16:0] exp_a;
    logic [7:0]  exp_d;
    bus.shadow = 8'h00;
    to_cnt0();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h01, 16'h2000 + 16'(i), 8'hA0 + 8'(i));
      #1;
      checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_%0d: got %b want 1", i, bus.cpu_ready); end
      step();
    end
    drive(1'b1, 8'h01, 16'h2004, 8'hA4);
    #1;
    stalled_ok = 1'b1;
    n = 0;
    while (!m_slot && n < 40) begin
      if (bus.cpu_ready !== 1'b0) stalled_ok = 1'b0;
      step();
      n++;
    end
    checks++; if (stalled_ok !== 1'b1 || !m_slot) begin errors++; $display("FAIL ovf_stall: stall_held=%b slot_reached=%b want 1/1", stalled_ok, m_slot); end
    checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL ovf_accept_at_pop: got %b want 1", bus.cpu_ready); end
    checks++; if (bus.slow_ce !== 1'b1 || bus.slow_addr !== 17'h12000 || bus.slow_din !== 8'hA0) begin errors++; $display("FAIL ovf_pop0: ce=%b addr=%h din=%h want 1/12000/a0", bus.slow_ce, bus.slow_addr, bus.slow_din); end
    step();
    idle_bus();
    for (int k = 1; k < 5; k++) begin
      exp_a = 17'h12000 + 17'(k);
      exp_d = 8'hA0 + 8'(k);
      wait_slot("ovf");
      checks++; if (bus.slow_ce !== 1'b1 || bus.slow_addr !== exp_a || bus.slow_din !== exp_d) begin errors++; $display("FAIL ovf_pop%0d: ce=%b addr=%h din=%h want 1/%h/%h", k, bus.slow_ce, bus.slow_addr, bus.slow_din, exp_a, exp_d); end
      step();
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ovf_drained: busy=%b want 0", bus.busy); end
  endtask

  task automatic test_ordering();
    logic [16:0] exp_a [3];
    logic        exp_w [3];
    logic [7:0]  exp_d [3];
    logic        stalled_ok;
    int          slots;
    int          n;
    exp_a = '{17'h00400, 17'h10500, 17'h00400};
    exp_w = '{1'b1, 1'b1, 1'b0};
    exp_d = '{8'h5A, 8'h33, 8'h00};
    bus.shadow = 8'h00;
    to_cnt0();
    drive(1'b1, 8'h00, 16'h0400, 8'h5A);
    step();
    drive(1'b1, 8'h01, 16'h0500, 8'h33);
    step();
    drive(1'b0, 8'hE0, 16'h0400, 8'h00);
    #1;
    stalled_ok = 1'b1;
    slots = 0;
    n = 0;
    while (slots < 3 && n < 60) begin
      if (bus.cpu_ready !== 1'b0) stalled_ok = 1'b0;
      if (m_slot) begin
        checks++;
        if (bus.slow_ce !== 1'b1 || bus.slow_we !== exp_w[slots] || bus.slow_addr !== exp_a[slots] ||
            (exp_w[slots] && bus.slow_din !== exp_d[slots])) begin
          errors++;
          $display("FAIL ord_slot%0d: ce=%b we=%b addr=%h din=%h want 1/%b/%h/%h", slots + 1,
                   bus.slow_ce, bus.slow_we, bus.slow_addr, bus.slow_din, exp_w[slots], exp_a[slots], exp_d[slots]);
        end
        slots++;
      end
      if (slots < 3) step();
      n++;
    end
    checks++; if (slots != 3 || stalled_ok !== 1'b1) begin errors++; $display("FAIL ord_stall: slots=%0d stall_held=%b want 3/1", slots, stalled_ok); end
    step();
    checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL ord_rdlat_ready: got %b want 0", bus.cpu_ready); end
    step();
    checks++; if (bus.cpu_ready !== 1'b1 || bus.cpu_slow_din !== 8'h5A) begin errors++; $display("FAIL ord_done: ready=%b din=%h want 1/5a", bus.cpu_ready, bus.cpu_slow_din); end
    idle_bus();
    step();
    checks++; if (bus.busy !== 1'b0 || bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL ord_idle: busy=%b ready=%b want 0/1", bus.busy, bus.cpu_ready); end
  endtask

  task automatic test_direct();
    drive(1'b1, 8'hE1, 16'h1234, 8'hC3);
    #1;
    checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL dwr_stall: got %b want 0", bus.cpu_ready); end
    step();
    wait_slot("dwr");
    checks++; if (bus.slow_ce !== 1'b1 || bus.slow_we !== 1'b1 || bus.slow_addr !== 17'h11234 || bus.slow_din !== 8'hC3) begin errors++; $display("FAIL dwr_issue: ce=%b we=%b addr=%h din=%h want 1/1/11234/c3", bus.slow_ce, bus.slow_we, bus.slow_addr, bus.slow_din); end
    step();
    checks++; if (bus.cpu_ready !== 1'b1 || bus.cpu_slow_din !== 8'h5A) begin errors++; $display("FAIL dwr_done: ready=%b din=%h want 1/5a", bus.cpu_ready, bus.cpu_slow_din); end
    idle_bus();
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dwr_idle: busy=%b want 0", bus.busy); end
    drive(1'b0, 8'hE1, 16'h1234, 8'h00);
    step();
    wait_slot("drd");
    checks++; if (bus.slow_ce !== 1'b1 || bus.slow_we !== 1'b0 || bus.slow_addr !== 17'h11234) begin errors++; $display("FAIL drd_issue: ce=%b we=%b addr=%h want 1/0/11234", bus.slow_ce, bus.slow_we, bus.slow_addr); end
    step();
    step();
    checks++; if (bus.cpu_ready !== 1'b1 || bus.cpu_slow_din !== 8'hC3) begin errors++; $display("FAIL drd_done: ready=%b din=%h want 1/c3", bus.cpu_ready, bus.cpu_slow_din); end
    idle_bus();
    step();
  endtask

  task automatic test_shr();
    logic exp_push;
`ifdef SHADOW_SHR_EN
    exp_push = 1'b1;
`else
    exp_push = 1'b0;
`endif
    bus.shadow = 8'h06;
    to_cnt0();
    drive(1'b1, 8'h01, 16'h8000, 8'h77);
    #1;
    checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL shr_ready: got %b want 1", bus.cpu_ready); end
    step();
    idle_bus();
    #1;
    checks++; if (bus.busy !== exp_push) begin errors++; $display("FAIL shr_push_06: busy=%b want %b", bus.busy, exp_push); end
    wait_slot("shr");
    checks++; if (bus.slow_ce !== exp_push || bus.slow_addr !== (exp_push ? 17'h18000 : 17'h00000)) begin errors++; $display("FAIL shr_pop: ce=%b addr=%h want %b", bus.slow_ce, bus.slow_addr, exp_push); end
    step();
    bus.shadow = 8'h0E;
    drive(1'b1, 8'h01, 16'h8000, 8'h78);
    step();
    idle_bus();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL shr_push_0e: busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int base;
    bus.shadow = 8'h00;
    to_cnt0();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h00, 16'h2000 + 16'(i), 8'h11 * 8'(i + 1));
      step();
    end
    drive(1'b1, 8'hE0, 16'h3000, 8'h99);
    #1;
    checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %b want 0", bus.cpu_ready); end
    step();
    step();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre: got %b want 1", bus.busy); end
    reset = 1'b1;
    idle_bus();
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.cpu_ready !== 1'b1 || bus.slow_ce !== 1'b0) begin errors++; $display("FAIL rmid_reset: busy=%b ready=%b ce=%b want 0/1/0", bus.busy, bus.cpu_ready, bus.slow_ce); end
    step();
    reset = 1'b0;
    base = ce_pulses;
    repeat (32) step();
    checks++; if (ce_pulses != base) begin errors++; $display("FAIL rmid_stale: %0d slow_ce pulses after reset, want 0", ce_pulses - base); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_post: got %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_shadow_basic();
    test_shadow_inhibit();
    test_overflow();
    test_ordering();
    test_direct();
    test_shr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
